// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 10-bit binary to 4-digit packed BCD converter.
// Uses double-dabble, one iteration per clock: 1 accept edge, 10 shift
// edges, a one-cycle DONE state, then back to IDLE (12 cycles per result
// when start is held high).
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset
//   start  in   1   convert request, only looked at in IDLE
//   bin    in  10   value to convert, captured on the accepting edge
//   ready  out  1   FSM in IDLE
//   busy   out  1   FSM in SHIFT
//   done   out  1   one-cycle pulse, bcd holds the new result
//   bcd    out 16   {thousands, hundreds, tens, units}

// Per-digit add-3 correction. One instance per BCD nibble.
module bcd_nibble_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);
  localparam int NUM_DIG = 4;
  localparam int BIN_W   = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  // work[25:10] = BCD digits, work[9:0] = binary shift register (MSB first)
  logic [25:0] work;
  logic [25:0] work_pre;
  logic [25:0] work_sh;
  logic [3:0]  cnt;
  logic [15:0] adj_bcd;
  logic        last_iter;

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      bcd_nibble_adj u_adj (
        .din  (work[BIN_W + 4*g +: 4]),
        .dout (adj_bcd[4*g +: 4])
      );
    end
  endgenerate

  // Correct digits first, then shift the whole register by one.
  assign work_pre  = {adj_bcd, work[BIN_W-1:0]};
  assign work_sh   = work_pre << 1;
  assign last_iter = (cnt == 4'd9);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and status outputs
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_iter) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: work register, iteration counter, result register.
  // bcd is only written on the edge that moves SHIFT -> DONE, so an aborted
  // conversion never exposes a partial value.
  always_ff @(posedge clk) begin
    if (reset) begin
      work <= '0;
      cnt  <= '0;
      bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= {16'h0000, bin};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          work <= work_sh;
          cnt  <= cnt + 4'd1;
          if (last_iter) bcd <= work_sh[25:10];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, exhaustive sweep,
// random values with noise on start/bin, per-cycle protocol monitor.
module tb_bin2bcd_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  bin;
  logic        ready, busy, done;
  logic [15:0] bcd;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;
  bit mon_en  = 0;
  logic        rst_q = 1'b1;
  logic [15:0] prev_bcd = '0;

  bin2bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits of v by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit digits_ok(input logic [15:0] b);
    digits_ok = (b[15:12] <= 4'd1) && (b[11:8] <= 4'd9) &&
                (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // Per-cycle monitor: one-hot status, legal digits, bcd holds outside DONE entry.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", 32'($countones({ready, busy, done})), 32'd1);
      chk("digits", {31'd0, digits_ok(bcd)}, 32'd1);
      if (!done && !rst_q) chk("bcd_hold", bcd, prev_bcd);
      if (done) n_done++;
    end
    prev_bcd = bcd;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  // One conversion; optional noise on start/bin while the block is busy.
  task automatic convert(input int v, input bit noise);
    int lat;
    int d0;
    wait_ready();
    start = 1'b1;
    bin   = 10'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 10'($urandom);
    d0    = n_done;
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
      if (done) start = 1'b0;
      else if (noise) begin
        start = 1'($urandom_range(0, 1));
        bin   = 10'($urandom);
      end
    end while (!done && lat < 40);
    chk("latency", 32'(lat), 32'd11);
    chk("bcd", bcd, ref_bcd(v));
    start = 1'b0;
    @(negedge clk);
    chk("ready_after", {31'd0, ready}, 32'd1);
    if (noise) begin
      repeat (15) @(negedge clk);
      chk("single_done", 32'(n_done - d0), 32'd1);
    end
  endtask

  initial begin
    int v;
    int t;
    int last_cyc;
    int vals [3] = '{10, 20, 30};
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_bcd",   bcd, 32'h0000);
    mon_en = 1;

    convert(255, 0);
    chk("bcd_255", bcd, 32'h0255);
    convert(0, 0);
    convert(1023, 0);
    chk("bcd_1023", bcd, 32'h1023);
    convert(999, 0);
    convert(1000, 0);

    // Start during SHIFT ignored
    convert(42, 1);
    chk("bcd_42", bcd, 32'h0042);

    // Reset mid-operation at iteration 5
    convert(255, 0);
    wait_ready();
    start = 1'b1;
    bin   = 10'd512;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    t = n_done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_bcd", bcd, 32'h0000);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(n_done - t), 32'd0);
    convert(77, 0);

    // Back-to-back with start held high
    wait_ready();
    start    = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      bin = 10'(vals[k]);
      t = 0;
      while (!ready && t < 30) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1;
      bin = 10'($urandom);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 40);
      chk("b2b_done", {31'd0, done}, 32'd1);
      chk("b2b_bcd", bcd, ref_bcd(vals[k]));
      if (k > 0) chk("b2b_period", 32'(cyc - last_cyc), 32'd12);
      last_cyc = cyc;
      @(negedge clk);
    end
    start = 1'b0;

    // Exhaustive
    for (int i = 0; i < 1024; i++) convert(i, 0);

    // Random values, random idle gaps, noise on inputs
    for (int i = 0; i < 100; i++) begin
      v = int'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(v, 1'($urandom_range(0, 1)));
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
